spi_flash_sequencer: RTL and testbench

- Command-level controller sitting between the JTAG host logic and the spi_interface byte engine.
- Accepts READ, PROGRAM, ERASE and STATUS commands and writes opcode/address headers and payload into the engine's TX FIFO.
- Starts the engine through the work/op/len/busy handshake, inserts WREN before PROGRAM/ERASE, and polls flash status (WIP bit) until the write completes or times out.

---
 rtl/spi_flash_pkg.sv | 44 ++++
 rtl/spi_flash_txloader.sv | 100 ++++++++++
 rtl/spi_flash_sequencer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_spi_flash_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash command sequencer.
package spi_flash_pkg;

  typedef enum logic [1:0] {
    CMD_READ    = 2'd0,
    CMD_PROGRAM = 2'd1,
    CMD_ERASE   = 2'd2,
    CMD_STATUS  = 2'd3
  } cmd_code_t;

  localparam logic [7:0] OP_WREN    = 8'h06;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_PROGRAM = 8'h02;
  localparam logic [7:0] OP_ERASE   = 8'h20;
  localparam logic [7:0] OP_RDSR    = 8'h05;

  localparam int HDR_BITS = 24;
  localparam int WIP_BIT  = 0;

  // Sequencer states, kept as plain constants so the encoding stays fixed.
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_CHECK    = 4'd1;
  localparam state_t ST_LD_WREN  = 4'd2;
  localparam state_t ST_RUN_WREN = 4'd3;
  localparam state_t ST_LD_HDR   = 4'd4;
  localparam state_t ST_LD_PL    = 4'd5;
  localparam state_t ST_RUN_CMD  = 4'd6;
  localparam state_t ST_LD_POLL  = 4'd7;
  localparam state_t ST_RUN_POLL = 4'd8;
  localparam state_t ST_POP_ST   = 4'd9;
  localparam state_t ST_EVAL     = 4'd10;
  localparam state_t ST_FINISH   = 4'd11;

  function automatic logic [7:0] cmd_opcode(input cmd_code_t c);
    case (c)
      CMD_READ:    return OP_READ;
      CMD_PROGRAM: return OP_PROGRAM;
      CMD_ERASE:   return OP_ERASE;
      default:     return OP_RDSR;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_txloader.sv
// Pushes a 1..3 byte header followed by an optional host payload into the
// engine TX FIFO, stalling on tx_full without dropping or repeating bytes.
module spi_flash_txloader #(
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      hdr_cnt,
  input  logic [8:0]      pl_cnt,
  input  logic [DATA-1:0] hdr0,
  input  logic [DATA-1:0] hdr1,
  input  logic [DATA-1:0] hdr2,
  input  logic            pl_valid,
  input  logic [DATA-1:0] pl_data,
  output logic            pl_ready,
  output logic            pl_phase,
  output logic [DATA-1:0] tx_wdata,
  output logic            tx_wr,
  input  logic            tx_full,
  output logic            done
);

  typedef enum logic [1:0] {PH_IDLE, PH_HDR, PH_PL} phase_t;

  phase_t          phase;
  logic [1:0]      idx;
  logic [1:0]      hcnt_q;
  logic [8:0]      pl_left;
  logic [DATA-1:0] h0_q, h1_q, h2_q;
  logic [DATA-1:0] hdr_byte;

  // Write strobe and data are combinational so a full FIFO blocks the write
  // in the very cycle it is flagged.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    hdr_byte = h0_q;
    tx_wdata = '0;
    case (idx)
      2'd1:    hdr_byte = h1_q;
      2'd2:    hdr_byte = h2_q;
      default: hdr_byte = h0_q;
    endcase
    pl_phase = (phase == PH_PL);
    pl_ready = pl_phase && !tx_full;
    tx_wr    = ((phase == PH_HDR) && !tx_full) || (pl_ready && pl_valid);
    if (phase == PH_HDR)     tx_wdata = hdr_byte;
    else if (phase == PH_PL) tx_wdata = pl_data;
  end

  // Walk header bytes, then payload bytes, and pulse done after the last one.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= only; blocking assignments here would
    // make readers of these registers depend on block evaluation order.
    if (rst) begin
      phase   <= PH_IDLE;
      idx     <= '0;
      hcnt_q  <= '0;
      pl_left <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (phase)
        PH_IDLE: if (start) begin
          h0_q    <= hdr0;
          h1_q    <= hdr1;
          h2_q    <= hdr2;
          hcnt_q  <= hdr_cnt;
          pl_left <= pl_cnt;
          idx     <= '0;
          phase   <= PH_HDR;
        end
        PH_HDR: if (!tx_full) begin
          if (idx == hcnt_q - 2'd1) begin
            if (pl_left == '0) begin
              phase <= PH_IDLE;
              done  <= 1'b1;
            end else begin
              phase <= PH_PL;
            end
          end else begin
            idx <= idx + 2'd1;
          end
        end
        PH_PL: if (pl_valid && !tx_full) begin
          pl_left <= pl_left - 9'd1;
          if (pl_left == 9'd1) begin
            phase <= PH_IDLE;
            done  <= 1'b1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_flash_sequencer.sv
// Command-level SPI flash controller: turns READ/PROGRAM/ERASE/STATUS host
// commands into TX FIFO loads and engine transfers, inserting WREN before
// writes and polling the WIP bit until the write finishes or times out.
module spi_flash_sequencer
  import spi_flash_pkg::*;
#(
  parameter int          DATA      = 8,
  parameter int          MAX_BYTES = 32,
  parameter logic [15:0] POLL_MAX  = 16'd4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_code,
  input  logic [15:0]     cmd_addr,
  input  logic [8:0]      cmd_nbytes,
  input  logic            pl_valid,
  input  logic [DATA-1:0] pl_data,
  output logic            pl_ready,
  output logic            done,
  output logic            error,
  output logic [DATA-1:0] status_byte,
  output logic            polling,
  output logic            eng_work,
  output logic            eng_op,
  output logic [15:0]     eng_len,
  input  logic            eng_busy,
  output logic [DATA-1:0] tx_wdata,
  output logic            tx_wr,
  input  logic            tx_full,
  input  logic [DATA-1:0] rx_rdata,
  output logic            rx_rd,
  input  logic            rx_empty
);

  localparam logic [8:0] MAX_NB = 9'(MAX_BYTES);

  state_t          state;
  cmd_code_t       code_q;
  logic [15:0]     addr_q;
  logic [8:0]      nbytes_q;
  logic            err_q;
  logic            out_of_reset;
  logic            seen_busy;
  logic [2:0]      wait_cnt;
  logic [15:0]     poll_cnt;
  logic [DATA-1:0] status_q;

  logic            ld_start;
  logic [DATA-1:0] ld_h0, ld_h1, ld_h2;
  logic [1:0]      ld_hcnt;
  logic [8:0]      ld_pcnt;
  logic            ld_done;
  logic            ld_pl_phase;

  logic            in_run, eng_complete, eng_timeout;
  logic            is_write_cmd, bad_len;
  logic            cmd_op;
  logic [15:0]     cmd_len;
  logic [DATA-1:0] cmd_a1, cmd_a0;
  logic [8:0]      cmd_pcnt;

  // Per-command header/length decode and engine handshake status.
  always_comb begin
    is_write_cmd = (code_q == CMD_PROGRAM) || (code_q == CMD_ERASE);
    bad_len      = ((code_q == CMD_READ) || (code_q == CMD_PROGRAM)) &&
                   ((nbytes_q == '0) || (nbytes_q > MAX_NB));
    cmd_op       = is_write_cmd;
    cmd_a1       = DATA'(addr_q[15:8]);
    cmd_a0       = DATA'(addr_q[7:0]);
    cmd_pcnt     = (code_q == CMD_PROGRAM) ? nbytes_q : 9'd0;
    cmd_len      = 16'(HDR_BITS) + {4'd0, nbytes_q, 3'd0};
    if (code_q == CMD_STATUS) begin
      cmd_a1  = '0;
      cmd_a0  = '0;
      cmd_len = 16'(HDR_BITS + 8);
    end else if (code_q == CMD_ERASE) begin
      cmd_len = 16'(HDR_BITS);
    end
    in_run       = (state == ST_RUN_WREN) || (state == ST_RUN_CMD) ||
                   (state == ST_RUN_POLL);
    eng_complete = in_run && seen_busy && !eng_busy;
    // Busy must show up by the fourth cycle after the work pulse.
    eng_timeout  = in_run && !seen_busy && !eng_busy && !eng_work &&
                   (wait_cnt == 3'd3);
  end

  // Host-facing and RX-side strobes decoded from the current state.
  always_comb begin
    cmd_ready   = (state == ST_IDLE) && out_of_reset;
    done        = (state == ST_FINISH);
    error       = (state == ST_FINISH) && err_q;
    polling     = (state == ST_LD_POLL) || (state == ST_RUN_POLL) ||
                  (state == ST_POP_ST)  || (state == ST_EVAL);
    rx_rd       = (state == ST_POP_ST) && !rx_empty;
    status_byte = status_q;
  end

  // Main command sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      code_q       <= CMD_READ;
      addr_q       <= '0;
      nbytes_q     <= '0;
      err_q        <= 1'b0;
      out_of_reset <= 1'b0;
      seen_busy    <= 1'b0;
      wait_cnt     <= '0;
      poll_cnt     <= '0;
      status_q     <= '0;
      eng_work     <= 1'b0;
      eng_op       <= 1'b0;
      eng_len      <= '0;
      ld_start     <= 1'b0;
      ld_h0        <= '0;
      ld_h1        <= '0;
      ld_h2        <= '0;
      ld_hcnt      <= '0;
      ld_pcnt      <= '0;
    end else begin
      out_of_reset <= 1'b1;
      eng_work     <= 1'b0;
      ld_start     <= 1'b0;

      if (in_run) begin
        if (eng_busy)                     seen_busy <= 1'b1;
        else if (!seen_busy && !eng_work) wait_cnt  <= wait_cnt + 3'd1;
      end

      case (state)
        ST_IDLE: if (cmd_valid && cmd_ready) begin
          code_q   <= cmd_code_t'(cmd_code);
          addr_q   <= cmd_addr;
          nbytes_q <= cmd_nbytes;
          err_q    <= 1'b0;
          poll_cnt <= '0;
          state    <= ST_CHECK;
        end

        ST_CHECK: begin
          if (bad_len) begin
            err_q <= 1'b1;
            state <= ST_FINISH;
          end else if (is_write_cmd) begin
            ld_start <= 1'b1;
            ld_h0    <= DATA'(OP_WREN);
            ld_h1    <= '0;
            ld_h2    <= '0;
            ld_hcnt  <= 2'd1;
            ld_pcnt  <= '0;
            state    <= ST_LD_WREN;
          end else begin
            ld_start <= 1'b1;
            ld_h0    <= DATA'(cmd_opcode(code_q));
            ld_h1    <= cmd_a1;
            ld_h2    <= cmd_a0;
            ld_hcnt  <= 2'd3;
            ld_pcnt  <= cmd_pcnt;
            state    <= ST_LD_HDR;
          end
        end

        ST_LD_WREN: if (ld_done) begin
          eng_work  <= 1'b1;
          eng_op    <= 1'b1;
          eng_len   <= 16'd8;
          seen_busy <= 1'b0;
          wait_cnt  <= '0;
          state     <= ST_RUN_WREN;
        end

        ST_LD_HDR, ST_LD_PL: begin
          if (state == ST_LD_HDR && ld_pl_phase) begin
            state <= ST_LD_PL;
          end else if (ld_done) begin
            eng_work  <= 1'b1;
            eng_op    <= cmd_op;
            eng_len   <= cmd_len;
            seen_busy <= 1'b0;
            wait_cnt  <= '0;
            state     <= ST_RUN_CMD;
          end
        end

        ST_LD_POLL: if (ld_done) begin
          eng_work  <= 1'b1;
          eng_op    <= 1'b0;
          eng_len   <= 16'(HDR_BITS + 8);
          seen_busy <= 1'b0;
          wait_cnt  <= '0;
          state     <= ST_RUN_POLL;
        end

        ST_RUN_WREN, ST_RUN_CMD, ST_RUN_POLL: begin
          if (eng_timeout) begin
            err_q   <= 1'b1;
            eng_op  <= 1'b0;
            eng_len <= '0;
            state   <= ST_FINISH;
          end else if (eng_complete) begin
            eng_op  <= 1'b0;
            eng_len <= '0;
            if (state == ST_RUN_WREN) begin
              ld_start <= 1'b1;
              ld_h0    <= DATA'(cmd_opcode(code_q));
              ld_h1    <= cmd_a1;
              ld_h2    <= cmd_a0;
              ld_hcnt  <= 2'd3;
              ld_pcnt  <= cmd_pcnt;
              state    <= ST_LD_HDR;
            end else if (state == ST_RUN_POLL) begin
              state <= ST_POP_ST;
            end else if (is_write_cmd) begin
              ld_start <= 1'b1;
              ld_h0    <= DATA'(OP_RDSR);
              ld_h1    <= '0;
              ld_h2    <= '0;
              ld_hcnt  <= 2'd3;
              ld_pcnt  <= '0;
              state    <= ST_LD_POLL;
            end else begin
              state <= ST_FINISH;
            end
          end
        end

        ST_POP_ST: if (!rx_empty) begin
          status_q <= rx_rdata;
          state    <= ST_EVAL;
        end

        ST_EVAL: begin
          if (!status_q[WIP_BIT]) begin
            state <= ST_FINISH;
          end else if (poll_cnt + 16'd1 >= POLL_MAX) begin
            poll_cnt <= POLL_MAX;
            err_q    <= 1'b1;
            state    <= ST_FINISH;
          end else begin
            poll_cnt <= poll_cnt + 16'd1;
            ld_start <= 1'b1;
            ld_h0    <= DATA'(OP_RDSR);
            ld_h1    <= '0;
            ld_h2    <= '0;
            ld_hcnt  <= 2'd3;
            ld_pcnt  <= '0;
            state    <= ST_LD_POLL;
          end
        end

        ST_FINISH: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_flash_txloader #(.DATA(DATA)) u_txloader (
    .clk      (clk),
    .rst      (rst),
    .start    (ld_start),
    .hdr_cnt  (ld_hcnt),
    .pl_cnt   (ld_pcnt),
    .hdr0     (ld_h0),
    .hdr1     (ld_h1),
    .hdr2     (ld_h2),
    .pl_valid (pl_valid),
    .pl_data  (pl_data),
    .pl_ready (pl_ready),
    .pl_phase (ld_pl_phase),
    .tx_wdata (tx_wdata),
    .tx_wr    (tx_wr),
    .tx_full  (tx_full),
    .done     (ld_done)
  );

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Directed bench for spi_flash_sequencer with behavioural TX/RX FIFOs,
// a byte engine and a flash status responder.
module tb_spi_flash_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_code = 2'd0;
  logic [15:0] cmd_addr = 16'd0;
  logic [8:0]  cmd_nbytes = 9'd0;
  logic        pl_valid = 1'b0;
  logic [7:0]  pl_data = 8'd0;
  logic        pl_ready;
  logic        done, error, polling;
  logic [7:0]  status_byte;
  logic        eng_work, eng_op;
  logic [15:0] eng_len;
  logic        eng_busy = 1'b0;
  logic [7:0]  tx_wdata;
  logic        tx_wr;
  logic        tx_full = 1'b0;
  logic [7:0]  rx_rdata = 8'd0;
  logic        rx_rd;
  logic        rx_empty = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  pl_src[$];
  logic [7:0]  rx_q[$];
  logic        work_op[$];
  logic [15:0] work_len[$];
  int          busy_left = 0;
  bit          cur_poll = 1'b0;
  int          poll_k = 0;
  int          wip_ones = 0;
  int          done_cnt = 0;

  spi_flash_sequencer #(.DATA(8), .MAX_BYTES(32), .POLL_MAX(16'd4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
    .done(done), .error(error), .status_byte(status_byte), .polling(polling),
    .eng_work(eng_work), .eng_op(eng_op), .eng_len(eng_len), .eng_busy(eng_busy),
    .tx_wdata(tx_wdata), .tx_wr(tx_wr), .tx_full(tx_full),
    .rx_rdata(rx_rdata), .rx_rd(rx_rd), .rx_empty(rx_empty)
  );

  always #5 clk = ~clk;

  // TX FIFO sink: record every accepted write.
  always @(posedge clk) if (tx_wr) tx_q.push_back(tx_wdata);

  // Done pulse counter.
  always @(posedge clk) if (done) done_cnt++;

  // Payload source feeding pl_valid/pl_data from pl_src.
  always @(posedge clk) begin
    if (pl_valid && pl_ready && pl_src.size() > 0) void'(pl_src.pop_front());
    pl_valid <= (pl_src.size() > 0);
    pl_data  <= (pl_src.size() > 0) ? pl_src[0] : 8'd0;
  end

  // Engine: busy for 3 cycles after work; status polls deliver one RX byte.
  always @(posedge clk) begin
    if (rst) begin
      busy_left = 0;
      eng_busy <= 1'b0;
      rx_q.delete();
    end else begin
      if (rx_rd && rx_q.size() > 0) void'(rx_q.pop_front());
      if (eng_work) begin
        work_op.push_back(eng_op);
        work_len.push_back(eng_len);
        cur_poll  = polling;
        busy_left = 3;
        eng_busy <= 1'b1;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          eng_busy <= 1'b0;
          if (cur_poll) begin
            rx_q.push_back((poll_k < wip_ones) ? 8'h01 : 8'h00);
            poll_k++;
          end
        end
      end
    end
    rx_empty <= (rx_q.size() == 0);
    rx_rdata <= (rx_q.size() > 0) ? rx_q[0] : 8'd0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_tx(input string tag);
    check({tag, "_count"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), tx_q[i], exp_q[i]);
  endtask

  task automatic clear_logs();
    tx_q.delete();
    work_op.delete();
    work_len.delete();
    poll_k = 0;
  endtask

  task automatic issue(input logic [1:0] code, input logic [15:0] addr, input logic [8:0] nb);
    @(negedge clk);
    check("cmd_ready_before_issue", cmd_ready, 1'b1);
    cmd_valid  = 1'b1;
    cmd_code   = code;
    cmd_addr   = addr;
    cmd_nbytes = nb;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc, output logic err);
    bit seen;
    seen = 1'b0;
    err  = 1'bx;
    for (int i = 0; i < maxc && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        err  = error;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
  endtask

  initial begin
    logic err;
    int   dc, wc;
    bit   found;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", {cmd_ready, pl_ready, done, error, polling, eng_work, eng_op, tx_wr, rx_rd}, 9'd0);
    check("rst_len", eng_len, 16'd0);
    check("rst_status", status_byte, 8'd0);
    check("rst_wdata", tx_wdata, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1'b1);

    // READ 0x1234, 4 bytes
    clear_logs();
    issue(2'd0, 16'h1234, 9'd4);
    wait_done("read", 100, err);
    check("read_err", err, 1'b0);
    exp_q = '{8'h03, 8'h12, 8'h34};
    check_tx("read_tx");
    check("read_works", work_op.size(), 1);
    if (work_op.size() >= 1) begin
      check("read_op", work_op[0], 1'b0);
      check("read_len", work_len[0], 16'd56);
    end

    // PROGRAM 0x0100, payload AA 55, WIP high for two polls
    @(negedge clk);
    clear_logs();
    wip_ones = 2;
    pl_src = '{8'hAA, 8'h55};
    issue(2'd1, 16'h0100, 9'd2);
    wait_done("prog", 400, err);
    check("prog_err", err, 1'b0);
    check("prog_status", status_byte, 8'h00);
    check("prog_polls", poll_k, 3);
    exp_q = '{8'h06, 8'h02, 8'h01, 8'h00, 8'hAA, 8'h55,
              8'h05, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00};
    check_tx("prog_tx");
    check("prog_works", work_op.size(), 5);
    if (work_op.size() >= 3) begin
      check("prog_wren_op", work_op[0], 1'b1);
      check("prog_wren_len", work_len[0], 16'd8);
      check("prog_cmd_op", work_op[1], 1'b1);
      check("prog_cmd_len", work_len[1], 16'd40);
      check("prog_poll_op", work_op[2], 1'b0);
      check("prog_poll_len", work_len[2], 16'd32);
    end

    // ERASE with WIP stuck: POLL_MAX=4 polls then error
    @(negedge clk);
    clear_logs();
    wip_ones = 1000;
    issue(2'd2, 16'h2000, 9'd0);
    wait_done("erase", 600, err);
    check("erase_err", err, 1'b1);
    check("erase_polls", poll_k, 4);
    check("erase_status", status_byte, 8'h01);
    exp_q = '{8'h06, 8'h20, 8'h20, 8'h00,
              8'h05, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00,
              8'h05, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00};
    check_tx("erase_tx");
    if (work_op.size() >= 2) begin
      check("erase_op", work_op[1], 1'b1);
      check("erase_len", work_len[1], 16'd24);
    end

    // READ with nbytes 0 and MAX_BYTES+1: immediate error
    @(negedge clk);
    clear_logs();
    issue(2'd0, 16'h0000, 9'd0);
    wait_done("nb0", 3, err);
    check("nb0_err", err, 1'b1);
    @(negedge clk);
    issue(2'd0, 16'h0000, 9'd33);
    wait_done("nb33", 3, err);
    check("nb33_err", err, 1'b1);
    check("badlen_tx_count", tx_q.size(), 0);
    check("badlen_work_count", work_op.size(), 0);

    // PROGRAM with tx_full asserted for 5 cycles mid-payload
    @(negedge clk);
    clear_logs();
    wip_ones = 0;
    pl_src = '{8'h11, 8'h22, 8'h33, 8'h44};
    issue(2'd1, 16'h0A0B, 9'd4);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (pl_src.size() == 3) found = 1'b1;
      else @(negedge clk);
    end
    check("full_reach_payload", found, 1'b1);
    tx_full = 1'b1;
    repeat (5) begin
      #1;
      check("full_pl_ready", pl_ready, 1'b0);
      check("full_tx_wr", tx_wr, 1'b0);
      @(negedge clk);
    end
    check("full_no_consume", pl_src.size(), 3);
    tx_full = 1'b0;
    wait_done("full", 400, err);
    check("full_err", err, 1'b0);
    exp_q = '{8'h06, 8'h02, 8'h0A, 8'h0B, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h05, 8'h00, 8'h00};
    check_tx("full_tx");
    wc = work_op.size();
    if (wc >= 2) check("full_cmd_len", work_len[1], 16'd56);

    // Reset during RUN_POLL
    @(negedge clk);
    clear_logs();
    wip_ones = 1000;
    issue(2'd2, 16'h3000, 9'd0);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (poll_k >= 1 && polling && eng_busy) found = 1'b1;
      else @(negedge clk);
    end
    check("rp_reach_run_poll", found, 1'b1);
    check("rp_status_before", status_byte, 8'h01);
    dc  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rp_ctrl", {cmd_ready, pl_ready, done, error, polling, eng_work, eng_op, tx_wr, rx_rd}, 9'd0);
    check("rp_len", eng_len, 16'd0);
    check("rp_status", status_byte, 8'd0);
    check("rp_wdata", tx_wdata, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rp_ready_next", cmd_ready, 1'b1);
    repeat (3) @(negedge clk);
    check("rp_no_done", done_cnt, dc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
